// File: rtl/gb_camera_pkg.sv
// gb_camera_pkg: shared FSM states and image constants for the camera capture block
package gb_camera_pkg;
  typedef enum logic [2:0] {IDLE, EXPOSE, FETCH, WR_LO, WR_HI} state_t;
  localparam int IMG_W = 128;
  localparam int IMG_H = 112;
  localparam logic [12:0] IMG_BASE = 13'h100;
  localparam logic [6:0] REG_MATRIX = 7'h06;
endpackage

// File: rtl/gb_camera_dither.sv
// gb_camera_dither: maps a grayscale pixel to a 2-bit shade against three thresholds
module gb_camera_dither (
  input  logic [7:0] pix,
  input  logic [7:0] t0,
  input  logic [7:0] t1,
  input  logic [7:0] t2,
  output logic [1:0] shade
);
  always_comb shade = pix < t0 ? 2'd3 : pix < t1 ? 2'd2 : pix < t2 ? 2'd1 : 2'd0;
endmodule

// File: rtl/gb_camera_capture.sv
// gb_camera_capture: camera register file, exposure timer, dithering and tile writer into cart RAM
module gb_camera_capture
  import gb_camera_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce_cpu,
  input  logic        enable,
  input  logic        cam_en,
  input  logic        reg_wr,
  input  logic [6:0]  reg_addr,
  input  logic [7:0]  reg_di,
  output logic [7:0]  reg_do,
  output logic        pix_req,
  input  logic        pix_valid,
  input  logic [7:0]  pix_data,
  output logic        ram_wr,
  output logic [12:0] ram_addr,
  output logic [7:0]  ram_data,
  input  logic        ram_busy,
  output logic        busy
);
  state_t state;
  logic [1:0] ctrl;
  logic [7:0] exp_hi, exp_lo;
  logic [7:0] mtx [48];
  logic [6:0] x, y;
  logic [7:0] lo_sr, hi_sr;
  logic [19:0] exp_cnt;
  logic [19:0] exp_tgt;
  logic [6:0] moff;
  logic [5:0] mi;
  logic [1:0] shade;
  logic [7:0] lo_nx, hi_nx;
  logic [12:0] addr;
  logic rst, we, ctrl_wr;
  assign rst = !reset_n || !enable;
  assign we = ce_cpu && reg_wr && cam_en;
  assign ctrl_wr = we && reg_addr == 7'h00;
  assign moff = reg_addr - REG_MATRIX;
  assign exp_tgt = {exp_hi, exp_lo, 4'b0};
  assign mi = {2'b0, y[1:0], x[1:0]} * 6'd3;
  assign lo_nx = {lo_sr[6:0], shade[0]};
  assign hi_nx = {hi_sr[6:0], shade[1]};
  assign addr = IMG_BASE + {1'b0, y[6:3], x[6:3], y[2:0], 1'b0};
  assign reg_do = reg_addr == 7'h00 ? {5'b0, ctrl, busy} : 8'h00;
  gb_camera_dither u_dither (
    .pix(pix_data),
    .t0(mtx[mi]),
    .t1(mtx[mi + 6'd1]),
    .t2(mtx[mi + 6'd2]),
    .shade(shade)
  );
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      pix_req <= 1'b0;
      ram_wr <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      ctrl <= '0;
      exp_hi <= '0;
      exp_lo <= '0;
      x <= '0;
      y <= '0;
      lo_sr <= '0;
      hi_sr <= '0;
      exp_cnt <= '0;
      for (int i = 0; i < 48; i++) mtx[i] <= '0;
    end else begin
      if (we && moff < 7'd48) mtx[moff[5:0]] <= reg_di;
      if (we && reg_addr == 7'h02) exp_hi <= reg_di;
      if (we && reg_addr == 7'h03) exp_lo <= reg_di;
      if (ctrl_wr) ctrl <= reg_di[2:1];
      if (ctrl_wr && busy && !reg_di[0]) begin
        state <= IDLE;
        busy <= 1'b0;
        pix_req <= 1'b0;
        ram_wr <= 1'b0;
      end else begin
        case (state)
          IDLE: if (ctrl_wr && reg_di[0]) begin
            busy <= 1'b1;
            x <= '0;
            y <= '0;
            exp_cnt <= '0;
            state <= EXPOSE;
          end
          EXPOSE: if (exp_tgt == '0 || (ce_cpu && exp_cnt == exp_tgt - 20'd1)) begin
            state <= FETCH;
            pix_req <= 1'b1;
          end else if (ce_cpu) exp_cnt <= exp_cnt + 20'd1;
          FETCH: if (pix_valid) begin
            lo_sr <= lo_nx;
            hi_sr <= hi_nx;
            if (x[2:0] == 3'd7) begin
              state <= WR_LO;
              pix_req <= 1'b0;
              ram_wr <= 1'b1;
              ram_addr <= addr;
              ram_data <= lo_nx;
            end else x <= x + 7'd1;
          end
          WR_LO: if (!ram_busy) begin
            state <= WR_HI;
            ram_addr <= ram_addr + 13'd1;
            ram_data <= hi_sr;
          end
          WR_HI: if (!ram_busy) begin
            ram_wr <= 1'b0;
            x <= x + 7'd1;
            if (x == 7'(IMG_W - 1)) y <= y == 7'(IMG_H - 1) ? 7'd0 : y + 7'd1;
            if (x == 7'(IMG_W - 1) && y == 7'(IMG_H - 1)) begin
              state <= IDLE;
              busy <= 1'b0;
            end else begin
              state <= FETCH;
              pix_req <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_gb_camera_capture.sv
// tb_gb_camera_capture: table vectors plus scoreboard-checked captures for gb_camera_capture
module tb_gb_camera_capture;
  typedef struct {
    logic [7:0] pix, t0, t1, t2, lo, hi;
  } vec_t;
  typedef struct {
    logic [12:0] addr;
    logic [7:0] data;
  } sb_t;
  logic clk_sys = 1'b0;
  logic reset_n, ce_cpu, enable, cam_en, reg_wr, pix_req, ram_wr, ram_busy, busy;
  logic pix_valid;
  logic [6:0] reg_addr;
  logic [7:0] reg_di, reg_do, pix_data, ram_data;
  logic [12:0] ram_addr;
  logic busy_force, stall_rand, valid_rand, pix_rand;
  logic stall_bit = 1'b0;
  logic valid_bit = 1'b0;
  logic [7:0] pix_const;
  logic [7:0] m_mtx [48];
  logic [7:0] lo_m, hi_m;
  int px, py, tests, fails;
  sb_t exp_q[$];
  logic [12:0] wa[$];
  logic [7:0] wd[$];
  longint last_edge, fall_edge;
  vec_t vt[11];
  assign ram_busy = busy_force | (stall_rand & stall_bit);
  assign pix_valid = valid_bit;
  always #5 clk_sys = ~clk_sys;
  gb_camera_capture dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_cpu(ce_cpu), .enable(enable), .cam_en(cam_en),
    .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_di(reg_di), .reg_do(reg_do),
    .pix_req(pix_req), .pix_valid(pix_valid), .pix_data(pix_data),
    .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_data(ram_data), .ram_busy(ram_busy), .busy(busy)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask
  function automatic logic [1:0] ref_dither(input logic [7:0] p, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    if (p < a) return 2'd3;
    if (p < b) return 2'd2;
    if (p < c) return 2'd1;
    return 2'd0;
  endfunction
  task automatic model_accept(input logic [7:0] p);
    int c;
    logic [1:0] v;
    logic [12:0] a;
    c = (py % 4) * 4 + (px % 4);
    v = ref_dither(p, m_mtx[3*c], m_mtx[3*c+1], m_mtx[3*c+2]);
    lo_m = {lo_m[6:0], v[0]};
    hi_m = {hi_m[6:0], v[1]};
    if (px % 8 == 7) begin
      a = 13'(256 + ((py / 8) * 16 + px / 8) * 16 + (py % 8) * 2);
      exp_q.push_back('{a, lo_m});
      exp_q.push_back('{13'(a + 1), hi_m});
    end
    px++;
    if (px == 128) begin
      px = 0;
      py = (py + 1) % 112;
    end
  endtask
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic write_reg(input logic [6:0] a, input logic [7:0] d);
    reg_addr = a;
    reg_di = d;
    reg_wr = 1'b1;
    tick();
    reg_wr = 1'b0;
  endtask
  task automatic set_matrix(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    for (int i = 0; i < 16; i++) begin
      write_reg(7'(6 + 3 * i), a);
      write_reg(7'(7 + 3 * i), b);
      write_reg(7'(8 + 3 * i), c);
      m_mtx[3*i] = a;
      m_mtx[3*i+1] = b;
      m_mtx[3*i+2] = c;
    end
  endtask
  task automatic reset_model();
    for (int i = 0; i < 48; i++) m_mtx[i] = 8'h00;
    exp_q.delete();
  endtask
  task automatic start(input logic [7:0] d);
    px = 0;
    py = 0;
    exp_q.delete();
    write_reg(7'h00, d);
  endtask
  task automatic abort();
    write_reg(7'h00, 8'h00);
    chk("abort busy", busy, 0);
    chk("abort ram_wr", ram_wr, 0);
    chk("abort pix_req", pix_req, 0);
    exp_q.delete();
  endtask
  task automatic wait_writes(input int n, input int budget);
    int k = 0;
    while (wa.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("write count reached", wa.size(), n);
  endtask
  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    fall_edge = $time - 1;
    chk("capture finished", busy, 0);
  endtask
  task automatic chk_idle_outputs(input string nm);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " pix_req"}, pix_req, 0);
    chk({nm, " ram_wr"}, ram_wr, 0);
    chk({nm, " ram_addr"}, ram_addr, 0);
    chk({nm, " ram_data"}, ram_data, 0);
  endtask
  task automatic frame_checks(input logic [7:0] lo_want, input logic [7:0] hi_want);
    logic [12:0] mn, mx;
    logic [7:0] lo_and, lo_or, hi_and, hi_or;
    mn = 13'h1FFF;
    mx = 13'h0000;
    lo_and = 8'hFF;
    hi_and = 8'hFF;
    lo_or = 8'h00;
    hi_or = 8'h00;
    foreach (wa[i]) begin
      if (wa[i] < mn) mn = wa[i];
      if (wa[i] > mx) mx = wa[i];
      if (wa[i][0]) begin
        hi_and &= wd[i];
        hi_or |= wd[i];
      end else begin
        lo_and &= wd[i];
        lo_or |= wd[i];
      end
    end
    chk("frame write count", wa.size(), 3584);
    chk("frame min addr", mn, 13'h0100);
    chk("frame max addr", mx, 13'h0EFF);
    chk("frame last addr", wa[wa.size()-1], 13'h0EFF);
    chk("frame lo and", lo_and, lo_want);
    chk("frame lo or", lo_or, lo_want);
    chk("frame hi and", hi_and, hi_want);
    chk("frame hi or", hi_or, hi_want);
    chk("busy falls at last write", 32'(fall_edge - last_edge), 0);
    chk("scoreboard drained", exp_q.size(), 0);
  endtask
  initial begin
    pix_data = 8'h00;
    forever begin
      @(negedge clk_sys);
      if (pix_req && pix_valid) model_accept(pix_data);
      @(posedge clk_sys);
      #1;
      pix_data = pix_rand ? 8'($urandom_range(0, 255)) : pix_const;
      valid_bit = valid_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end
  initial forever begin
    @(posedge clk_sys);
    #1;
    stall_bit = $urandom_range(0, 7) == 0;
  end
  initial forever begin
    sb_t e;
    @(negedge clk_sys);
    if (ram_wr && !ram_busy) begin
      wa.push_back(ram_addr);
      wd.push_back(ram_data);
      last_edge = $time + 5;
      chk("write expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb addr", ram_addr, e.addr);
        chk("sb data", ram_data, e.data);
      end
    end
  end
  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int k, pulses;
    logic rd_ok;
    reset_n = 0; enable = 1; cam_en = 1; ce_cpu = 1; reg_wr = 0; reg_addr = 0; reg_di = 0;
    busy_force = 0; stall_rand = 0; valid_rand = 0; pix_rand = 0; pix_const = 0;
    lo_m = 0; hi_m = 0; px = 0; py = 0; tests = 0; fails = 0; last_edge = 0; fall_edge = 0;
    reset_model();
    vt[0] = '{8'h3F, 8'h40, 8'h80, 8'hC0, 8'hFF, 8'hFF};
    vt[1] = '{8'h40, 8'h40, 8'h80, 8'hC0, 8'h00, 8'hFF};
    vt[2] = '{8'h7F, 8'h40, 8'h80, 8'hC0, 8'h00, 8'hFF};
    vt[3] = '{8'h80, 8'h40, 8'h80, 8'hC0, 8'hFF, 8'h00};
    vt[4] = '{8'hBF, 8'h40, 8'h80, 8'hC0, 8'hFF, 8'h00};
    vt[5] = '{8'hC0, 8'h40, 8'h80, 8'hC0, 8'h00, 8'h00};
    vt[6] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
    vt[7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[8] = '{8'h00, 8'h01, 8'h01, 8'h01, 8'hFF, 8'hFF};
    vt[9] = '{8'h50, 8'h60, 8'h20, 8'h90, 8'hFF, 8'hFF};
    vt[10] = '{8'h70, 8'h60, 8'h20, 8'h90, 8'hFF, 8'h00};
    repeat (3) tick();
    chk_idle_outputs("reset");
    chk("reset reg_do", reg_do, 8'h00);
    reset_n = 1;
    tick();
    cam_en = 0;
    write_reg(7'h00, 8'h07);
    cam_en = 1;
    chk("cam_en gates writes", reg_do, 8'h00);
    ce_cpu = 0;
    write_reg(7'h00, 8'h07);
    ce_cpu = 1;
    chk("ce_cpu gates writes", reg_do, 8'h00);
    write_reg(7'h00, 8'h06);
    chk("ctrl bits stored idle", reg_do, 8'h06);
    reg_addr = 7'h01;
    #1;
    chk("other index reads zero", reg_do, 8'h00);
    write_reg(7'h00, 8'h00);
    for (int v = 0; v < 11; v++) begin
      set_matrix(vt[v].t0, vt[v].t1, vt[v].t2);
      pix_const = vt[v].pix;
      wa.delete();
      wd.delete();
      start(8'h01);
      wait_writes(2, 200);
      if (wd.size() >= 2) begin
        chk($sformatf("vec%0d lo", v), wd[0], vt[v].lo);
        chk($sformatf("vec%0d hi", v), wd[1], vt[v].hi);
      end
      abort();
    end
    for (int i = 0; i < 48; i++) begin
      m_mtx[i] = 8'($urandom_range(0, 255));
      write_reg(7'(6 + i), m_mtx[i]);
    end
    pix_rand = 1;
    wa.delete();
    wd.delete();
    start(8'h01);
    wait_writes(128, 3000);
    abort();
    pix_rand = 0;
    set_matrix(8'h40, 8'h80, 8'hC0);
    pix_const = 8'h00;
    wa.delete();
    wd.delete();
    start(8'h01);
    wait_idle(40000);
    frame_checks(8'hFF, 8'hFF);
    pix_const = 8'h90;
    stall_rand = 1;
    valid_rand = 1;
    wa.delete();
    wd.delete();
    start(8'h01);
    wait_idle(60000);
    frame_checks(8'hFF, 8'h00);
    chk("first write addr", wa[0], 13'h0100);
    chk("second write addr", wa[1], 13'h0101);
    stall_rand = 0;
    valid_rand = 0;
    busy_force = 1;
    wa.delete();
    wd.delete();
    start(8'h01);
    k = 0;
    while (!ram_wr && k < 50) begin
      tick();
      k++;
    end
    chk("stall first addr", ram_addr, 13'h0100);
    repeat (5) begin
      tick();
      chk("stall ram_wr", ram_wr, 1);
      chk("stall ram_addr", ram_addr, 13'h0100);
      chk("stall ram_data", ram_data, 8'hFF);
      chk("stall pix_req", pix_req, 0);
    end
    busy_force = 0;
    tick();
    chk("lo done count", wa.size(), 1);
    chk("hi addr", ram_addr, 13'h0101);
    chk("hi data", ram_data, 8'h00);
    chk("hi pending pix_req", pix_req, 0);
    tick();
    chk("hi done count", wa.size(), 2);
    chk("after hi ram_wr", ram_wr, 0);
    chk("after hi pix_req", pix_req, 1);
    abort();
    wa.delete();
    wd.delete();
    start(8'h01);
    wait_writes(10, 500);
    abort();
    chk("abort count", wa.size(), 10);
    repeat (100) tick();
    chk("no writes after abort", wa.size(), 10);
    write_reg(7'h02, 8'h00);
    write_reg(7'h03, 8'h02);
    start(8'h01);
    pulses = 0;
    rd_ok = 1;
    k = 0;
    while (!pix_req && k < 300) begin
      ce_cpu = (k % 3) != 2;
      @(posedge clk_sys);
      if (ce_cpu) pulses++;
      #1;
      if (!pix_req && reg_do !== 8'h01) rd_ok = 0;
      k++;
    end
    ce_cpu = 1;
    chk("exposure pulses", pulses, 32);
    chk("reg0 during expose", rd_ok, 1);
    write_reg(7'h00, 8'h07);
    chk("restart ignored busy", busy, 1);
    chk("restart stores bits", reg_do, 8'h07);
    abort();
    chk("abort reg0", reg_do, 8'h00);
    wa.delete();
    wd.delete();
    start(8'h01);
    k = 0;
    while (!pix_req && k < 100) begin
      tick();
      k++;
    end
    repeat (3) tick();
    reset_n = 0;
    tick();
    chk_idle_outputs("midfetch reset");
    chk("midfetch reset reg0", reg_do, 8'h00);
    reg_addr = 7'h02;
    #1;
    chk("midfetch reset reg2", reg_do, 8'h00);
    reset_n = 1;
    reset_model();
    repeat (20) tick();
    chk("no trailing write", wa.size(), 0);
    start(8'h01);
    tick();
    chk("exposure cleared by reset", pix_req, 1);
    wait_writes(2, 50);
    if (wd.size() >= 2) begin
      chk("zero matrix lo", wd[0], 8'h00);
      chk("zero matrix hi", wd[1], 8'h00);
    end
    abort();
    set_matrix(8'h40, 8'h80, 8'hC0);
    write_reg(7'h03, 8'h05);
    wa.delete();
    wd.delete();
    start(8'h07);
    chk("start with bits", reg_do, 8'h07);
    repeat (4) tick();
    enable = 0;
    tick();
    chk_idle_outputs("enable low");
    chk("enable low reg0", reg_do, 8'h00);
    write_reg(7'h00, 8'h07);
    chk("enable low ignores writes", reg_do, 8'h00);
    enable = 1;
    reset_model();
    start(8'h01);
    tick();
    chk("enable exposure cleared", pix_req, 1);
    wait_writes(2, 50);
    if (wd.size() >= 2) begin
      chk("enable zero matrix lo", wd[0], 8'h00);
      chk("enable zero matrix hi", wd[1], 8'h00);
    end
    abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gb_camera_capture.md
GB_CAMERA_CAPTURE -- requirements
Module: gb_camera_capture

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all ports are listed below.
- clk_sys  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  synchronous active-low reset.
- ce_cpu  in  1  CPU clock enable; register writes and exposure timing advance only when it is high.
- enable  in  1  camera mapper selected; low acts as a held reset.
- cam_en  in  1  mapper camera-register window active; gates reg_wr.
- reg_wr  in  1  CPU write strobe to the 0xA000-0xBFFF window.
- reg_addr  in  7  register index (cart_addr[6:0]).
- reg_di  in  8  CPU write data.
- reg_do  out  8  register read data.
- pix_req  out  1  request for the next grayscale pixel, in raster order.
- pix_valid  in  1  pixel present; a pixel is accepted when pix_req and pix_valid are both high.
- pix_data  in  8  grayscale value; 0 is black.
- ram_wr  out  1  cart RAM bank-0 write request.
- ram_addr  out  13  cart RAM byte address.
- ram_data  out  8  cart RAM write data.
- ram_busy  in  1  stall; a write completes on a cycle with ram_wr high and ram_busy low.
- busy  out  1  capture in progress; mirrors reg 0x00 bit0.

Function
REQ-002 Registers are written only when ce_cpu, reg_wr and cam_en are high. The register map is:
- 0x00 control: bit0 start/busy, bits2:1 stored.
- 0x01 gain, stored only.
- 0x02/0x03 exposure, high and low bytes.
- 0x04/0x05 stored only.
- 0x06-0x35 dither matrix: 16 cells x 3 thresholds (t0, t1, t2), cell c at 0x06+3c.
- Indices above 0x35 are ignored.
REQ-003 reg_do SHALL return {5'b0, ctrl[2:1], busy} for index 0x00 and 0x00 for all other indices; it is combinational.
REQ-004 The FSM states SHALL be IDLE, EXPOSE, FETCH, WR_LO, WR_HI.
REQ-005 A write of bit0=1 to reg 0x00 in IDLE SHALL set busy and enter EXPOSE on the next cycle, with the x and y counters cleared to 0.
REQ-006 EXPOSE SHALL count exposure*16 ce_cpu pulses and then enter FETCH; an exposure of 0 enters FETCH after one cycle.
REQ-007 In FETCH, pix_req SHALL be high. Each accepted pixel is dithered using matrix cell c=(y[1:0]*4)+x[1:0]:
- pix<t0 -> 3;
- else pix<t1 -> 2;
- else pix<t2 -> 1;
- else 0.
All comparisons are unsigned 8-bit.
REQ-008 The bit-0 plane of each 2-bit value SHALL shift into lo_sr and bit 1 into hi_sr, MSB first, so the leftmost pixel lands in bit7.
REQ-009 On acceptance of the pixel with x[2:0]=7, the FSM SHALL go to WR_LO with pix_req low on the next cycle.
REQ-010 The write address SHALL be addr = 0x100 + ((y>>3)*16 + (x>>3))*16 + (y&7)*2. WR_LO writes lo_sr at addr and WR_HI writes hi_sr at addr+1. Each state holds ram_wr, ram_addr and ram_data stable until ram_busy is low.
REQ-011 After the WR_HI write completes, x SHALL increment modulo 128. On wrap, y increments. When y wraps from 111 the FSM returns to IDLE and clears busy in the same cycle; otherwise it returns to FETCH.
REQ-012 A full capture SHALL write exactly 3584 bytes covering 0x0100-0x0EFF, and no other addresses.
REQ-013 A write of bit0=0 to reg 0x00 while busy SHALL abort: next state IDLE, busy=0, ram_wr=0, and no further writes.
REQ-014 A write of bit0=1 while busy SHALL be ignored apart from bits2:1, which are still stored.
REQ-015 Matrix writes during a capture SHALL take effect for pixels accepted from the following cycle onward.
REQ-016 enable=0 SHALL behave exactly as reset.

Reset
REQ-017 Reset (reset_n=0, or enable=0) SHALL produce the following:
- state IDLE;
- busy, pix_req and ram_wr at 0;
- ram_addr and ram_data at 0;
- all registers, including the matrix, at 0x00;
- x, y and the shift registers at 0.
REQ-018 Reset asserted mid-capture SHALL take effect at the next clock edge with no trailing RAM write.

Structure
REQ-019 Package gb_camera_pkg SHALL hold the FSM state enum and the constants IMG_W=128, IMG_H=112, IMG_BASE=13'h100, and REG_MATRIX=7'h06.
REQ-020 Sub-module gb_camera_dither SHALL contain the combinational 3-threshold comparison from REQ-007.

Verification
REQ-021 Matrix all 0x80 cells (t0=0x40, t1=0x80, t2=0xC0), exposure 0, constant pixel 0x00, start -> 3584 writes, every byte 0xFF; busy falls after the byte at 0x0EFF.
REQ-022 Same setup with pixel 0x90 -> lo bytes 0xFF, hi bytes 0x00; the first two writes go to 0x0100 and 0x0101.
REQ-023 Exposure 0x0002 -> first pix_req rises exactly after 32 ce_cpu pulses; reg_do at index 0x00 reads 0x01 meanwhile.
REQ-024 ram_busy held high for 5 cycles on the first write -> ram_wr, ram_addr=0x100 and ram_data stay stable; no pixel is requested until both writes complete.
REQ-025 Write 0x00 to reg 0x00 after 10 writes -> busy=0 next cycle; no writes afterward.
REQ-026 reset_n low for 1 cycle mid-FETCH -> all outputs 0 and reg 0x02 reads back as 0x00 state.
